unary_pair_streamer: RTL and testbench

- Upstream feeder for the unary adder stage. Accepts a pair of binary operands through a valid/ready handshake and serialises each into a thermometer-coded unary bitstream: value v becomes v ones followed by zeros, over a fixed frame of FRAME_LEN cycles.
- Generates the adder's enable and read/write mode controls: a read phase while the streams are emitted, then a write/drain phase so the adder can shift out its result.

---
 rtl/unary_pkg.sv | 32 +++
 rtl/unary_therm_bit.sv | 33 +++
 rtl/unary_pair_streamer.sv | 175 +++++++++++++++++
 tb/tb_unary_pair_streamer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared state encoding, default frame/drain lengths and sizing helpers
// for the unary pair streamer.
package unary_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int unsigned FRAME_LEN_DEF = 19;
    localparam int unsigned DRAIN_LEN_DEF = 20;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned res;
        int unsigned pow;
        res = 0;
        pow = 1;
        while (pow < n) begin
            pow = pow << 1;
            res = res + 1;
        end
        // a counter always needs at least one bit
        if (res == 0) res = 1;
        return res;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/unary_therm_bit.sv
// One thermometer-code lane: registers (count < value) while enabled,
// so the lane bit lines up with the registered frame counter.
module unary_therm_bit
    import unary_pkg::*;
#(
    parameter int unsigned CW = 5,
    parameter int unsigned W  = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [CW-1:0] i_cnt,
    input  logic [W-1:0]  i_val,
    output logic          o_bit
);

    logic [CW-1:0] w_val_ext;
    logic          r_bit;

    // i_val is already clipped to the frame length, which always fits in CW bits
    assign w_val_ext = CW'(i_val);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit <= 1'b0;
        end else begin
            r_bit <= i_en && (i_cnt < w_val_ext);
        end
    end

    assign o_bit = r_bit;

endmodule

// File: rtl/unary_pair_streamer.sv
// Accepts an operand pair and streams both as thermometer-coded frames,
// then runs a drain phase so the downstream unary adder can shift out.
//
// state  | meaning
// IDLE   | ready for an operand pair, adder disabled
// STREAM | emitting frame bit k = counter, adder in read/accumulate mode
// DRAIN  | adder enabled in write mode, streams forced low
module unary_pair_streamer
    import unary_pkg::*;
#(
    parameter int unsigned W         = 5,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned DRAIN_LEN = DRAIN_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] val_a,
    input  logic [W-1:0] val_b,
    input  logic         flush,
    output logic         a_out,
    output logic         b_out,
    output logic         en_out,
    output logic         rw_out,
    output logic         sat_a,
    output logic         sat_b,
    output logic         done
);

    localparam int unsigned   CW         = clog2(max_u(FRAME_LEN, DRAIN_LEN) + 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LEN - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [W-1:0]  r_ca;
    logic [W-1:0]  r_cb;
    logic [W-1:0]  w_ca_nxt;
    logic [W-1:0]  w_cb_nxt;
    logic          r_sat_a;
    logic          r_sat_b;
    logic          w_sat_a_nxt;
    logic          w_sat_b_nxt;
    logic          r_in_ready;
    logic          r_en;
    logic          r_rw;
    logic          r_done;
    logic          w_accept;
    logic          w_stream_nxt;
    logic          w_en_nxt;
    logic          w_rw_nxt;
    logic          w_rdy_nxt;
    logic          w_done_nxt;
    logic          w_a_bit;
    logic          w_b_bit;

    function automatic logic [W-1:0] clip(input logic [W-1:0] v);
        return (32'(v) > FRAME_LEN) ? W'(FRAME_LEN) : v;
    endfunction

    // flush beats a simultaneous handshake
    assign w_accept = in_valid && r_in_ready && (r_state == IDLE) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ca       <= '0;
            r_cb       <= '0;
            r_sat_a    <= 1'b0;
            r_sat_b    <= 1'b0;
            r_in_ready <= 1'b0;
            r_en       <= 1'b0;
            r_rw       <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ca       <= w_ca_nxt;
            r_cb       <= w_cb_nxt;
            r_sat_a    <= w_sat_a_nxt;
            r_sat_b    <= w_sat_b_nxt;
            r_in_ready <= w_rdy_nxt;
            r_en       <= w_en_nxt;
            r_rw       <= w_rw_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ca_nxt    = r_ca;
        w_cb_nxt    = r_cb;
        w_sat_a_nxt = r_sat_a;
        w_sat_b_nxt = r_sat_b;
        if (flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = STREAM;
                        w_cnt_nxt   = '0;
                        w_ca_nxt    = clip(val_a);
                        w_cb_nxt    = clip(val_b);
                        w_sat_a_nxt = (32'(val_a) > FRAME_LEN);
                        w_sat_b_nxt = (32'(val_b) > FRAME_LEN);
                    end
                end
                STREAM: begin
                    if (r_cnt == FRAME_LAST) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (r_cnt == DRAIN_LAST) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // outputs are decoded from the next state so they register in step with it
    always_comb begin
        w_stream_nxt = (w_state_nxt == STREAM);
        w_en_nxt     = (w_state_nxt != IDLE);
        w_rw_nxt     = (w_state_nxt == DRAIN);
        w_rdy_nxt    = (w_state_nxt == IDLE);
        w_done_nxt   = !flush && (r_state == DRAIN) && (r_cnt == DRAIN_LAST);
    end

    unary_therm_bit #(.CW(CW), .W(W)) u_therm_a (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_stream_nxt),
        .i_cnt (w_cnt_nxt),
        .i_val (w_ca_nxt),
        .o_bit (w_a_bit)
    );

    unary_therm_bit #(.CW(CW), .W(W)) u_therm_b (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_stream_nxt),
        .i_cnt (w_cnt_nxt),
        .i_val (w_cb_nxt),
        .o_bit (w_b_bit)
    );

    assign in_ready = r_in_ready;
    assign a_out    = w_a_bit;
    assign b_out    = w_b_bit;
    assign en_out   = r_en;
    assign rw_out   = r_rw;
    assign sat_a    = r_sat_a;
    assign sat_b    = r_sat_b;
    assign done     = r_done;

endmodule

// File: tb/tb_unary_pair_streamer.sv
// Scoreboard bench for unary_pair_streamer: stimulus queues expected frames,
// a negedge monitor replays each frame cycle by cycle against the outputs.
module tb_unary_pair_streamer;

    localparam int FL = 19;
    localparam int DL = 20;
    localparam int W  = 5;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic         flush    = 1'b0;
    logic [W-1:0] val_a    = '0;
    logic [W-1:0] val_b    = '0;
    logic         in_ready, a_out, b_out, en_out, rw_out, sat_a, sat_b, done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int ca;
        int cb;
        bit sa;
        bit sb;
        int abort_t;
        bit abort_rst;
        bit b2b;
        int acc_cyc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   busy    = 1'b0;
    int   t       = 0;
    bit   chk_b2b = 1'b0;

    unary_pair_streamer #(.W(W), .FRAME_LEN(FL), .DRAIN_LEN(DL)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .val_a    (val_a),
        .val_b    (val_b),
        .flush    (flush),
        .a_out    (a_out),
        .b_out    (b_out),
        .en_out   (en_out),
        .rw_out   (rw_out),
        .sat_a    (sat_a),
        .sat_b    (sat_b),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d cyc=%0d actual=%0b required=%0b", name, t, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_frame();
        if (cur.abort_t >= 0 && t == cur.abort_t) begin
            if (cur.abort_rst) begin
                chk("rst_en", en_out, 1'b0);
                chk("rst_rw", rw_out, 1'b0);
                chk("rst_a", a_out, 1'b0);
                chk("rst_b", b_out, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_rdy", in_ready, 1'b0);
                chk("rst_sat_a", sat_a, 1'b0);
                chk("rst_sat_b", sat_b, 1'b0);
            end else begin
                chk("flush_en", en_out, 1'b0);
                chk("flush_rw", rw_out, 1'b0);
                chk("flush_a", a_out, 1'b0);
                chk("flush_b", b_out, 1'b0);
                chk("flush_done", done, 1'b0);
                chk("flush_rdy", in_ready, 1'b1);
                chk("flush_sat_a", sat_a, cur.sa);
                chk("flush_sat_b", sat_b, cur.sb);
            end
            busy = 1'b0;
        end else if (t < FL) begin
            chk("str_a", a_out, (t < cur.ca));
            chk("str_b", b_out, (t < cur.cb));
            chk("str_en", en_out, 1'b1);
            chk("str_rw", rw_out, 1'b0);
            chk("str_rdy", in_ready, 1'b0);
            chk("str_done", done, 1'b0);
            chk("str_sat_a", sat_a, cur.sa);
            chk("str_sat_b", sat_b, cur.sb);
        end else if (t < FL + DL) begin
            chk("drn_a", a_out, 1'b0);
            chk("drn_b", b_out, 1'b0);
            chk("drn_en", en_out, 1'b1);
            chk("drn_rw", rw_out, 1'b1);
            chk("drn_rdy", in_ready, 1'b0);
            chk("drn_done", done, 1'b0);
        end else begin
            chk("done_pulse", done, 1'b1);
            chk("done_en", en_out, 1'b0);
            chk("done_rw", rw_out, 1'b0);
            chk("done_rdy", in_ready, 1'b1);
            chk("done_sat_a", sat_a, cur.sa);
            busy    = 1'b0;
            chk_b2b = 1'b1;
        end
        t++;
    endtask

    always @(negedge clk) begin
        if (busy) begin
            check_frame();
        end else begin
            if (chk_b2b && q.size() > 0 && q[0].b2b) chk("b2b_start", en_out, 1'b1);
            chk_b2b = 1'b0;
            if (en_out) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame", en_out, 1'b0);
                end else begin
                    cur  = q.pop_front();
                    busy = 1'b1;
                    t    = 0;
                    chk_int("latency", cyc, cur.acc_cyc + 1);
                    check_frame();
                end
            end else begin
                chk("idle_a", a_out, 1'b0);
                chk("idle_b", b_out, 1'b0);
                chk("idle_rw", rw_out, 1'b0);
                chk("idle_done", done, 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input bit keep, input bit b2b,
                        input int abort_t, input bit abort_rst);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        val_a    = W'(a);
        val_b    = W'(b);
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_wait", in_ready, 1'b1);
        e.ca        = (a > FL) ? FL : a;
        e.cb        = (b > FL) ? FL : b;
        e.sa        = (a > FL);
        e.sb        = (b > FL);
        e.abort_t   = abort_t;
        e.abort_rst = abort_rst;
        e.b2b       = b2b;
        e.acc_cyc   = cyc;
        q.push_back(e);
        tick();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("idle_wait", in_ready, 1'b1);
        repeat (2) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rdy_in_rst", in_ready, 1'b0);
        rst = 1'b0;
        tick();
        chk("rdy_after_rst", in_ready, 1'b1);
        chk("sat_a_after_rst", sat_a, 1'b0);
        chk("sat_b_after_rst", sat_b, 1'b0);
        tick();

        // basic, boundary and saturating pairs
        send(3, 5, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();
        send(0, 19, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();
        send(25, 31, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();
        repeat (3) tick();
        chk("sat_a_held", sat_a, 1'b1);
        chk("sat_b_held", sat_b, 1'b1);
        send(2, 1, 1'b0, 1'b0, -1, 1'b0);
        wait_idle();
        chk("sat_a_cleared", sat_a, 1'b0);
        chk("sat_b_cleared", sat_b, 1'b0);

        // back-to-back with in_valid held high
        send(4, 6, 1'b1, 1'b0, -1, 1'b0);
        send(19, 0, 1'b0, 1'b1, -1, 1'b0);
        wait_idle();

        // flush at drain cycle 4 (frame cycle 23)
        send(10, 8, 1'b0, 1'b0, FL + 5, 1'b0);
        repeat (FL + 4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("rdy_after_flush", in_ready, 1'b1);
        repeat (5) tick();

        // flush together with a handshake in IDLE
        flush    = 1'b1;
        in_valid = 1'b1;
        val_a    = W'(5);
        val_b    = W'(5);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_blocks_rdy", in_ready, 1'b1);
        chk("flush_blocks_en", en_out, 1'b0);
        repeat (3) tick();

        // async reset at frame cycle 7
        send(6, 9, 1'b0, 1'b0, 7, 1'b1);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rdy_after_midrst", in_ready, 1'b1);
        repeat (4) tick();

        chk_int("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
